// File: rtl/tlb_op_ctrl_pkg.sv
// Shared encodings and helpers for the TLB instruction controller (TLBP/TLBR/TLBWI).
// Optional feature macro: TLB_REFETCH_EN (refetch pulse after TLBR/TLBWI).
package tlb_op_ctrl_pkg;

    localparam int unsigned TLBNUM_DEF = 16;
    localparam int unsigned EH_W       = 32;
    localparam int unsigned VPN2_W     = 19;
    localparam int unsigned ASID_W     = 8;
    localparam int unsigned OP_W       = 2;
    localparam int unsigned ST_W       = 2;

    localparam logic [OP_W-1:0] OP_NOP   = 2'b00;
    localparam logic [OP_W-1:0] OP_TLBP  = 2'b01;
    localparam logic [OP_W-1:0] OP_TLBR  = 2'b10;
    localparam logic [OP_W-1:0] OP_TLBWI = 2'b11;

    // 2'b11 is unused and recovers to IDLE
    localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
    localparam logic [ST_W-1:0] ST_EXEC = 2'b01;
    localparam logic [ST_W-1:0] ST_RESP = 2'b10;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
    } tlb_req_t;

    function automatic logic [VPN2_W-1:0] eh_vpn2(input logic [EH_W-1:0] eh);
        return eh[31:13];
    endfunction

    function automatic logic [ASID_W-1:0] eh_asid(input logic [EH_W-1:0] eh);
        return eh[7:0];
    endfunction

endpackage

// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer between WB and the external TLB/CP0: IDLE -> EXEC -> RESP.
// Optional feature macro: TLB_REFETCH_EN (refetch pulse in RESP after unflushed TLBR/TLBWI).
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int unsigned TLBNUM = TLBNUM_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [OP_W-1:0]            op_type,
    input  logic                       flush,
    input  logic [EH_W-1:0]            c0_entryhi,
    input  logic [31:0]                c0_index,
    output logic [VPN2_W-1:0]          s_vpn2,
    output logic [ASID_W-1:0]          s_asid,
    input  logic                       s_found,
    input  logic [$clog2(TLBNUM)-1:0]  s_index,
    output logic [$clog2(TLBNUM)-1:0]  r_index,
    output logic                       we,
    output logic [$clog2(TLBNUM)-1:0]  w_index,
    output logic                       tlbp,
    output logic                       tlbp_found,
    output logic [$clog2(TLBNUM)-1:0]  tlbp_index,
    output logic                       tlbr,
    output logic                       busy,
    output logic                       refetch
);

    localparam int unsigned IDX_W = $clog2(TLBNUM);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    tlb_req_t         r_req;
    logic [IDX_W-1:0] r_idx;
    logic             r_found;
    logic [IDX_W-1:0] r_sidx;
    logic             w_ready;
    logic             w_accept;
    logic             w_unused_bits;

    // Index is taken modulo TLBNUM; upper Index bits and EntryHi[12:8] are don't-care
    assign w_unused_bits = ^{c0_index[31:IDX_W], c0_entryhi[12:8]};

    assign w_ready  = resetn && (r_state == ST_IDLE) && !flush;
    assign w_accept = op_valid && w_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch: held across the whole op so search/read/write ports stay stable
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_req.op   <= op_type;
            r_req.vpn2 <= eh_vpn2(c0_entryhi);
            r_req.asid <= eh_asid(c0_entryhi);
            r_idx      <= c0_index[IDX_W-1:0];
        end
    end

    // TLB search answers combinationally in EXEC; capture it for the RESP strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_found <= 1'b0;
            r_sidx  <= '0;
        end else if ((r_state == ST_EXEC) && (r_req.op == OP_TLBP)) begin
            r_found <= s_found;
            r_sidx  <= s_index;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        we          = 1'b0;
        tlbr        = 1'b0;
        tlbp        = 1'b0;
        refetch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                    we          = (r_req.op == OP_TLBWI);
                    tlbr        = (r_req.op == OP_TLBR);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (!flush) begin
                    tlbp = (r_req.op == OP_TLBP);
`ifdef TLB_REFETCH_EN
                    refetch = (r_req.op == OP_TLBR) || (r_req.op == OP_TLBWI);
`else
                    refetch = 1'b0;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign op_ready   = w_ready;
    assign busy       = (r_state != ST_IDLE);
    assign s_vpn2     = r_req.vpn2;
    assign s_asid     = r_req.asid;
    assign r_index    = r_idx;
    assign w_index    = r_idx;
    assign tlbp_found = r_found;
    assign tlbp_index = r_sidx;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Randomized + directed bench for tlb_op_ctrl against an op-age reference model.
module tb_tlb_op_ctrl;

    localparam logic [1:0] T_NOP = 2'b00, T_P = 2'b01, T_R = 2'b10, T_WI = 2'b11;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_type;
    logic        flush;
    logic [31:0] c0_entryhi;
    logic [31:0] c0_index;
    logic [18:0] s_vpn2;
    logic [7:0]  s_asid;
    logic        s_found;
    logic [3:0]  s_index;
    logic [3:0]  r_index;
    logic        we;
    logic [3:0]  w_index;
    logic        tlbp;
    logic        tlbp_found;
    logic [3:0]  tlbp_index;
    logic        tlbr;
    logic        busy;
    logic        refetch;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: the op in flight and how many cycles since it was accepted
    int          m_age;
    logic [1:0]  m_op;
    logic [31:0] m_eh;
    logic [3:0]  m_idx;
    logic        m_found;
    logic [3:0]  m_sidx;

    always #5 clk = ~clk;

    tlb_op_ctrl #(.TLBNUM(16)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready),
        .op_type(op_type), .flush(flush), .c0_entryhi(c0_entryhi), .c0_index(c0_index),
        .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
        .r_index(r_index), .we(we), .w_index(w_index), .tlbp(tlbp),
        .tlbp_found(tlbp_found), .tlbp_index(tlbp_index), .tlbr(tlbr),
        .busy(busy), .refetch(refetch)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_age = 0; m_op = 2'b00; m_eh = '0; m_idx = '0; m_found = 1'b0; m_sidx = '0;
    endtask

    // One clock cycle: drive at negedge, check outputs, then advance the model at posedge
    task automatic cyc(input logic rst, input logic opv, input logic [1:0] opt,
                       input logic fl, input logic [31:0] eh, input logic [31:0] ci,
                       input logic sf, input logic [3:0] si);
        logic e_ready, e_we, e_tlbr, e_tlbp, e_rf;
        @(negedge clk);
        resetn = rst; op_valid = opv; op_type = opt; flush = fl;
        c0_entryhi = eh; c0_index = ci; s_found = sf; s_index = si;
        if (!rst) model_clear();
        #1;
        e_ready = rst && (m_age == 0) && !fl;
        e_we    = (m_age == 1) && (m_op == T_WI) && !fl;
        e_tlbr  = (m_age == 1) && (m_op == T_R) && !fl;
        e_tlbp  = (m_age == 2) && (m_op == T_P) && !fl;
`ifdef TLB_REFETCH_EN
        e_rf    = (m_age == 2) && ((m_op == T_R) || (m_op == T_WI)) && !fl;
`else
        e_rf    = 1'b0;
`endif
        chk("op_ready", 32'(op_ready), 32'(e_ready));
        chk("busy",     32'(busy),     32'(m_age != 0));
        chk("we",       32'(we),       32'(e_we));
        chk("tlbr",     32'(tlbr),     32'(e_tlbr));
        chk("tlbp",     32'(tlbp),     32'(e_tlbp));
        chk("refetch",  32'(refetch),  32'(e_rf));
        chk("s_vpn2",   32'(s_vpn2),   32'(m_eh[31:13]));
        chk("s_asid",   32'(s_asid),   32'(m_eh[7:0]));
        chk("r_index",  32'(r_index),  32'(m_idx));
        chk("w_index",  32'(w_index),  32'(m_idx));
        if (e_tlbp) begin
            chk("tlbp_found", 32'(tlbp_found), 32'(m_found));
            chk("tlbp_index", 32'(tlbp_index), 32'(m_sidx));
        end
        @(posedge clk);
        if (rst) begin
            case (m_age)
                0: if (opv && !fl) begin
                       m_op = opt; m_eh = eh; m_idx = ci[3:0]; m_age = 1;
                   end
                1: begin
                       if (m_op == T_P) begin m_found = sf; m_sidx = si; end
                       m_age = fl ? 0 : 2;
                   end
                default: m_age = 0;
            endcase
        end
    endtask

    task automatic idle_cyc(input logic sf, input logic [3:0] si);
        cyc(1'b1, 1'b0, T_NOP, 1'b0, 32'h0, 32'h0, sf, si);
    endtask

    initial begin
        resetn = 1'b0; op_valid = 1'b0; op_type = T_NOP; flush = 1'b0;
        c0_entryhi = '0; c0_index = '0; s_found = 1'b0; s_index = '0;
        model_clear();
        cyc(1'b0, 1'b0, T_NOP, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, T_P,   1'b0, 32'hFFFF_FFFF, 32'hF, 1'b1, 4'd5);
        idle_cyc(1'b0, 4'd0);

        // TLBP hit
        cyc(1'b1, 1'b1, T_P, 1'b0, 32'h0040_2005, 32'h0, 1'b0, 4'd0);
        idle_cyc(1'b1, 4'd7);
        idle_cyc(1'b0, 4'd0);
        idle_cyc(1'b0, 4'd0);
        // TLBP miss
        cyc(1'b1, 1'b1, T_P, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 4'd0);
        idle_cyc(1'b0, 4'd9);
        idle_cyc(1'b1, 4'd3);
        idle_cyc(1'b0, 4'd0);
        // TLBWI index 12
        cyc(1'b1, 1'b1, T_WI, 1'b0, 32'hABCD_E0FF, 32'h0000_000C, 1'b0, 4'd0);
        idle_cyc(1'b0, 4'd0);
        idle_cyc(1'b0, 4'd0);
        idle_cyc(1'b0, 4'd0);
        // TLBR index 3 with op_valid held high back to back
        for (int i = 0; i < 7; i++)
            cyc(1'b1, 1'b1, T_R, 1'b0, 32'h0000_2001, 32'h0000_0003, 1'b0, 4'd0);
        idle_cyc(1'b0, 4'd0);
        idle_cyc(1'b0, 4'd0);
        // TLBWI flushed in EXEC
        cyc(1'b1, 1'b1, T_WI, 1'b0, 32'h0000_4000, 32'h0000_0005, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, T_NOP, 1'b1, 32'h0, 32'h0, 1'b0, 4'd0);
        idle_cyc(1'b0, 4'd0);
        idle_cyc(1'b0, 4'd0);
        // flush together with op_valid in IDLE is not accepted
        cyc(1'b1, 1'b1, T_WI, 1'b1, 32'h0000_6000, 32'h0000_0006, 1'b0, 4'd0);
        idle_cyc(1'b0, 4'd0);
        // reset during EXEC of a TLBP
        cyc(1'b1, 1'b1, T_P, 1'b0, 32'h0040_2005, 32'h0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, T_NOP, 1'b0, 32'h0, 32'h0, 1'b1, 4'd7);
        cyc(1'b0, 1'b0, T_NOP, 1'b0, 32'h0, 32'h0, 1'b1, 4'd7);
        idle_cyc(1'b1, 4'd7);
        idle_cyc(1'b0, 4'd0);
        // NOP goes through with no strobes
        cyc(1'b1, 1'b1, T_NOP, 1'b0, 32'hDEAD_BEEF, 32'h0000_000A, 1'b1, 4'd1);
        idle_cyc(1'b1, 4'd1);
        idle_cyc(1'b1, 4'd1);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                32'($urandom),
                32'($urandom),
                1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
